result_dumper: RTL

//   Downstream readout stage for the compute datapath. After the controller has filled the

---
 rtl/result_dumper_pkg.sv | 13 +
 rtl/result_dumper_word_serializer.sv | 35 +++
 rtl/result_dumper.sv | 75 +++++++
 3 files changed

// File: rtl/result_dumper_pkg.sv
// result_dumper_pkg: shared widths and FSM state encoding for the result readout path
package result_dumper_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_LOAD,
    ST_SEND,
    ST_FIN
  } state_t;
endpackage

// File: rtl/result_dumper_word_serializer.sv
// word_serializer: splits one loaded word into bytes, MSB first, over valid/ready
module word_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  output logic              last
);
  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W = NBYTES > 1 ? $clog2(NBYTES) : 1;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  byte_idx;
  assign byte_data = shreg[DATA_W-1 -: 8];
  assign last = byte_valid & byte_ready & (byte_idx == IDX_W'(NBYTES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      byte_idx   <= '0;
      byte_valid <= 1'b0;
    end else if (load) begin
      shreg      <= data;
      byte_idx   <= '0;
      byte_valid <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      shreg      <= shreg << 8;
      byte_idx   <= byte_idx + 1'b1;
      byte_valid <= !last;
    end
  end
endmodule

// File: rtl/result_dumper.sv
// result_dumper: walks result RAM port B and streams each word as bytes, MSB first
module result_dumper
  import result_dumper_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done
);
  state_t            state;
  logic [ADDR_W:0]   words_left;
  logic [ADDR_W-1:0] addr_cnt;
  logic              last;
  word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (state == ST_LOAD),
    .data       (rd_data),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .last       (last)
  );
  // busy stays up through the done cycle and drops once back in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      words_left <= '0;
      addr_cnt   <= '0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= start;
          if (start) begin
            words_left <= count;
            addr_cnt   <= '0;
            state      <= count == '0 ? ST_FIN : ST_ADDR;
          end
        end
        ST_ADDR: begin
          rd_addr <= addr_cnt;
          state   <= ST_WAIT;
        end
        ST_WAIT: state <= ST_LOAD;
        ST_LOAD: state <= ST_SEND;
        ST_SEND: begin
          if (last) begin
            words_left <= words_left - 1'b1;
            addr_cnt   <= addr_cnt + 1'b1;
            state      <= words_left == (ADDR_W + 1)'(1) ? ST_FIN : ST_ADDR;
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
